// File: rtl/mat_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_scan_pkg                                                 |
// | Description : Shared 8x8 block geometry and zigzag-to-raster address map.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mat_scan_pkg;

    localparam int MAT_N  = 8;
    localparam int MAT_SZ = MAT_N * MAT_N;
    localparam int IDX_W  = 6;

    typedef logic [IDX_W-1:0] idx_t;

    // Entry k is the raster address (8*row + col) of the k-th zigzag coefficient.
    localparam idx_t ZZ2RASTER [MAT_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic idx_t zz2raster(input idx_t idx);
        return ZZ2RASTER[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_pp_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_pp_buf                                                   |
// | Description : Two-bank 64-entry coefficient store, one write port and one  |
// |               registered read port. Bank selection is owned by the parent. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mat_pp_buf
    import mat_scan_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_bank,
    input  idx_t              i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_rd_bank,
    input  idx_t              i_rd_addr,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2*MAT_SZ];
    logic [DATA_W-1:0] r_rd_data;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/mat_unscan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_unscan                                                   |
// | Description : Inverse zigzag reorder of 8x8 blocks, zigzag in / raster out,|
// |               ping-pong banked for one coefficient per cycle each way.     |
// |               Define MAT_UNSCAN_LAST_EN to add the last_out port.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mat_unscan
    import mat_scan_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_in,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] din,
    output logic              vld_out,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] dout
`ifdef MAT_UNSCAN_LAST_EN
    ,
    output logic              last_out
`endif
);

    localparam idx_t c_last_idx = IDX_W'(MAT_SZ - 1);

    idx_t        r_wr_cnt;
    idx_t        r_rd_cnt;
    logic        r_wb;
    logic        r_rb;
    logic [1:0]  r_full;
    logic [1:0]  w_full_nxt;
    logic        r_vld_out;
    logic        w_wr_fire;
    logic        w_rd_fire;
    idx_t        w_wr_addr;

    assign in_rdy    = !r_full[r_wb];
    assign w_wr_fire = vld_in && in_rdy;
    // A new word is fetched whenever the output register is empty or being drained.
    assign w_rd_fire = r_full[r_rb] && (!r_vld_out || out_rdy);
    assign w_wr_addr = zz2raster(r_wr_cnt);

    // Write and read never target the same bank, so set and clear cannot collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && (r_wr_cnt == c_last_idx)) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_rd_fire && (r_rd_cnt == c_last_idx)) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_full    <= '0;
            r_vld_out <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (r_wr_cnt == c_last_idx) begin
                    r_wb <= !r_wb;
                end
            end
            if (w_rd_fire) begin
                r_vld_out <= 1'b1;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == c_last_idx) begin
                    r_rb <= !r_rb;
                end
            end else if (out_rdy) begin
                r_vld_out <= 1'b0;
            end
        end
    end

    mat_pp_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_bank (r_wb),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (din),
        .i_wr_en   (w_wr_fire),
        .i_rd_bank (r_rb),
        .i_rd_addr (r_rd_cnt),
        .i_rd_en   (w_rd_fire),
        .o_rd_data (dout)
    );

    assign vld_out = r_vld_out;

`ifdef MAT_UNSCAN_LAST_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_rd_fire) begin
            r_last <= (r_rd_cnt == c_last_idx);
        end else if (out_rdy) begin
            r_last <= 1'b0;
        end
    end

    assign last_out = r_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_unscan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mat_unscan                                                |
// | Description : Scoreboard bench for mat_unscan (optionally with last_out).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mat_unscan;

    localparam int DATA_W = 10;

    localparam int ZZ [64] = '{
        0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic              clk = 1'b0;
    logic              rst;
    logic              vld_in;
    logic              in_rdy;
    logic [DATA_W-1:0] din;
    logic              vld_out;
    logic              out_rdy;
    logic [DATA_W-1:0] dout;
`ifdef MAT_UNSCAN_LAST_EN
    logic              last_out;
`endif

    always #5 clk = ~clk;

    mat_unscan #(
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .in_rdy   (in_rdy),
        .din      (din),
        .vld_out  (vld_out),
        .out_rdy  (out_rdy),
        .dout     (dout)
`ifdef MAT_UNSCAN_LAST_EN
        ,
        .last_out (last_out)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   q[$];
    bit   mon_en = 1'b0;
    bit   gap_chk = 1'b0;
    bit   rand_rdy = 1'b0;
    int   gaps = 0;
    int   cyc = 0;
    int   first_vld_cyc = -1;
    int   last_acc_cyc = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each output transfer, checks stall stability.
    logic [DATA_W-1:0] prev_dout;
    bit                prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 32'(dout), 32'(prev_dout));
            if (vld_out && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (gap_chk && first_vld_cyc >= 0 && q.size() > 0 && !vld_out) gaps++;
            if (vld_out && out_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0d required=none", dout);
                end else begin
                    int exp;
                    exp = q.pop_front();
                    chk("dout", 32'(dout), 32'(exp));
`ifdef MAT_UNSCAN_LAST_EN
                    chk("last_out", 32'(last_out), 32'((exp % 64) == 63));
`endif
                end
            end
            prev_stall = vld_out && !out_rdy;
            prev_dout  = dout;
        end
    end

    task automatic send_coef(input int val);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        din = DATA_W'(val);
        vld_in = 1'b1;
        while (!acc) begin
            acc = in_rdy;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=%0d required=accepted", t);
                return;
            end
        end
        last_acc_cyc = cyc;
    endtask

    task automatic send_block(input int b, input int n, input bit gapped);
        if (n == 64) begin
            for (int r = 0; r < 64; r++) q.push_back(64 * b + r);
        end
        for (int k = 0; k < n; k++) begin
            if (gapped && $urandom_range(0, 2) == 0) begin
                vld_in = 1'b0;
                @(posedge clk);
                #1;
            end
            send_coef(64 * b + ZZ[k]);
        end
        vld_in = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        int acc_n;
        bit a;
        rst = 1'b1;
        vld_in = 1'b0;
        din = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_vld_out", 32'(vld_out), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);

        // Single block, latency and no input stall.
        first_vld_cyc = -1;
        stall_cnt = 0;
        send_block(0, 64, 1'b0);
        wait_drain();
        chk("t1_latency", 32'(first_vld_cyc), 32'(last_acc_cyc + 1));
        chk("t1_in_stall", 32'(stall_cnt), 32'd0);

        // Three back-to-back blocks, contiguous gap-free output.
        repeat (2) @(posedge clk);
        #1;
        first_vld_cyc = -1;
        gaps = 0;
        gap_chk = 1'b1;
        send_block(0, 64, 1'b0);
        send_block(1, 64, 1'b0);
        send_block(2, 64, 1'b0);
        wait_drain();
        gap_chk = 1'b0;
        chk("t2_gaps", 32'(gaps), 32'd0);

        // Full backpressure: both banks fill, then drain.
        repeat (2) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        acc_n = 0;
        for (int r = 0; r < 128; r++) q.push_back(r);
        for (int i = 0; i < 200; i++) begin
            din = DATA_W'(64 * (acc_n / 64) + ZZ[acc_n % 64]);
            vld_in = 1'b1;
            a = in_rdy;
            @(posedge clk);
            #1;
            if (a) acc_n++;
        end
        vld_in = 1'b0;
        chk("t3_accepted", 32'(acc_n), 32'd128);
        chk("t3_in_rdy", 32'(in_rdy), 32'd0);
        chk("t3_vld_out", 32'(vld_out), 32'd1);
        chk("t3_dout", 32'(dout), 32'd0);
        out_rdy = 1'b1;
        wait_drain();

        // Random backpressure and input gaps over 10 blocks.
        rand_rdy = 1'b1;
        for (int b = 0; b < 10; b++) send_block(b, 64, 1'b1);
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_rdy = 1'b1;

        // Reset in the middle of a block.
        send_block(0, 64, 1'b0);
        send_block(1, 64, 1'b0);
        send_block(2, 30, 1'b0);
        do_reset();
        chk("t5_vld_out", 32'(vld_out), 32'd0);
        chk("t5_in_rdy", 32'(in_rdy), 32'd1);
        chk("t5_dout", 32'(dout), 32'd0);
        send_block(0, 64, 1'b0);
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("end_vld_out", 32'(vld_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
